vga_mem_arbiter: RTL
====================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, memory word address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width (two 8-bit pixels).
REQ-003 SHALL have parameter HOST_VBLANK_ONLY, default 0; 1 restricts host accesses to vertical blanking.
REQ-004 SHALL have parameter STARVE_LIMIT, default 1023, host wait cycles before the starve flag sets.
REQ-005 SHALL have one clock, in_vga_clk, and reset is asynchronous and active-low, named in_reset_n.
REQ-006 SHALL have ports (name, direction, width, meaning):
- in_vga_clk  in  1  pixel clock; all flops on the falling edge
- in_reset_n  in  1  async active-low reset
- in_v_blank  in  1  high during vertical blanking (from the sync generator)
- in_disp_req  in  1  display fetch request, single-cycle strobe
- in_disp_addr  in  ADDR_W  display fetch address
- out_disp_data  out  DATA_W  display read data
- out_disp_valid  out  1  display data valid strobe
- in_host_req  in  1  host access request, level
- in_host_we  in  1  1 = write, 0 = read
- in_host_addr  in  ADDR_W  host address
- in_host_wdata  in  DATA_W  host write data
- out_host_ack  out  1  request accepted strobe
- out_host_rdata  out  DATA_W  host read data
- out_host_rvalid  out  1  host read data valid strobe
- out_host_starved  out  1  host wait counter reached STARVE_LIMIT
- out_mem_addr  out  ADDR_W  SRAM address, registered
- out_mem_we  out  1  SRAM write enable, registered
- out_mem_wdata  out  DATA_W  SRAM write data, registered
- in_mem_rdata  in  DATA_W  SRAM read data, valid one cycle after address

Function
REQ-007 SHALL decide one issue slot per clock: the slot is DISP, HOST or IDLE, held in a state register that reflects the access issued this cycle.
REQ-008 SHALL select DISP whenever in_disp_req=1, regardless of host state (display absolute priority).
REQ-009 SHALL select HOST when in_disp_req=0, in_host_req=1 and host is eligible, else IDLE.
REQ-010 SHALL make host eligible always when HOST_VBLANK_ONLY=0; when HOST_VBLANK_ONLY=1, only when in_v_blank=1.
REQ-011 SHALL on DISP register out_mem_addr=in_disp_addr, out_mem_we=0.
REQ-012 SHALL on HOST register out_mem_addr=in_host_addr, out_mem_we=in_host_we, out_mem_wdata=in_host_wdata, and pulse out_host_ack for exactly that cycle.
REQ-013 SHALL on IDLE drive out_mem_we=0 and hold out_mem_addr and out_mem_wdata unchanged.
REQ-014 SHALL track issued reads with a 2-stage tag pipeline (none/disp/host) so returning data is routed to its owner.
REQ-015 SHALL assert out_disp_valid with out_disp_data=in_mem_rdata exactly 2 clocks after the DISP issue edge, for 1 cycle.
REQ-016 SHALL assert out_host_rvalid with out_host_rdata exactly 2 clocks after a host read issue edge; host writes produce no rvalid.
REQ-017 SHALL hold out_disp_data and out_host_rdata unchanged while their valid strobes are low.
REQ-018 SHALL accept back-to-back host accesses, one per cycle, when no display request intervenes; the host changes or drops its request in the cycle after ack.
REQ-019 SHALL, when a host request is blocked by display or blanking, generate no ack; the host holds its request stable until ack.
REQ-020 SHALL count consecutive cycles with in_host_req=1 and no ack, saturating at STARVE_LIMIT; the count clears on ack or when in_host_req=0.
REQ-021 SHALL set out_host_starved while the count equals STARVE_LIMIT.

Reset
REQ-022 SHALL on in_reset_n=0 asynchronously force: state IDLE, tags none, out_mem_we=0, out_mem_addr=0, out_mem_wdata=0, out_disp_valid=0, out_host_ack=0, out_host_rvalid=0, out_disp_data=0, out_host_rdata=0, counter 0, out_host_starved=0.
REQ-023 SHALL discard in-flight reads at reset; no valid strobe follows for accesses issued before reset.

Verification
REQ-024 SHALL cover this case: disp_req at addr 0x00010, mem returns 0xA55A -> out_mem_addr=0x00010 next cycle, out_disp_valid=1 with 0xA55A 2 clocks after issue.
REQ-025 SHALL cover this case: disp_req and host read at 0x00020 in the same cycle -> DISP issued, no ack; host acked the next cycle with disp_req=0, rvalid 2 clocks later.
REQ-026 SHALL cover this case: host writes 0x1234 to 0x00005, 3 back-to-back -> 3 ack pulses, out_mem_we=1 for 3 cycles, no rvalid.
REQ-027 SHALL cover this case: HOST_VBLANK_ONLY=1, host_req with in_v_blank=0 -> no ack; in_v_blank rises -> ack on the next issue edge.
REQ-028 SHALL cover this case: STARVE_LIMIT=4, disp_req held high 6 cycles with host_req high -> out_host_starved=1 after 4 blocked cycles, clears on ack.
REQ-029 SHALL cover this case: in_reset_n low 1 cycle after a DISP issue -> all outputs 0 and no out_disp_valid pulse afterwards.

Source files
------------

// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle for the VGA SRAM arbiter: display fetch port, host port and SRAM port.
// The master modport is the arbiter's view; slave is the surrounding logic's view.
interface vga_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
);
  logic              in_disp_req;
  logic [ADDR_W-1:0] in_disp_addr;
  logic [DATA_W-1:0] out_disp_data;
  logic              out_disp_valid;

  logic              in_host_req;
  logic              in_host_we;
  logic [ADDR_W-1:0] in_host_addr;
  logic [DATA_W-1:0] in_host_wdata;
  logic              out_host_ack;
  logic [DATA_W-1:0] out_host_rdata;
  logic              out_host_rvalid;
  logic              out_host_starved;

  logic [ADDR_W-1:0] out_mem_addr;
  logic              out_mem_we;
  logic [DATA_W-1:0] out_mem_wdata;
  logic [DATA_W-1:0] in_mem_rdata;

  modport master (
    input  in_disp_req, in_disp_addr,
    input  in_host_req, in_host_we, in_host_addr, in_host_wdata,
    input  in_mem_rdata,
    output out_disp_data, out_disp_valid,
    output out_host_ack, out_host_rdata, out_host_rvalid, out_host_starved,
    output out_mem_addr, out_mem_we, out_mem_wdata
  );

  modport slave (
    output in_disp_req, in_disp_addr,
    output in_host_req, in_host_we, in_host_addr, in_host_wdata,
    output in_mem_rdata,
    input  out_disp_data, out_disp_valid,
    input  out_host_ack, out_host_rdata, out_host_rvalid, out_host_starved,
    input  out_mem_addr, out_mem_we, out_mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port SRAM arbiter: display fetches win every slot, host fills the gaps.
// All flops run on the falling edge of the pixel clock; read data returns 2 clocks after issue.
module vga_mem_arbiter #(
  parameter int unsigned ADDR_W           = 18,
  parameter int unsigned DATA_W           = 16,
  parameter int unsigned HOST_VBLANK_ONLY = 0,
  parameter int unsigned STARVE_LIMIT     = 1023
) (
  input  logic                  in_vga_clk,
  input  logic                  in_reset_n,
  input  logic                  in_v_blank,
  vga_mem_arbiter_if.master     bus
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_HOST} slot_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} tag_e;

  slot_e             state_q, slot_d;
  tag_e              tag_q, tag_issue_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              host_eligible_c;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, disp_data_d, host_rdata_d;
  logic              mem_we_d, ack_d, disp_valid_d, host_rvalid_d, starved_d;

  assign host_eligible_c = (HOST_VBLANK_ONLY == 0) || in_v_blank;

  // Slot decision, SRAM command, read-return routing and starvation counter
  always_comb begin
    slot_d        = SLOT_IDLE;
    mem_addr_d    = bus.out_mem_addr;
    mem_wdata_d   = bus.out_mem_wdata;
    mem_we_d      = 1'b0;
    ack_d         = 1'b0;
    tag_issue_c   = TAG_NONE;
    disp_valid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    disp_data_d   = bus.out_disp_data;
    host_rdata_d  = bus.out_host_rdata;
    cnt_d         = cnt_q;

    if (bus.in_disp_req) begin
      slot_d     = SLOT_DISP;
      mem_addr_d = bus.in_disp_addr;
    end else if (bus.in_host_req && host_eligible_c) begin
      slot_d      = SLOT_HOST;
      mem_addr_d  = bus.in_host_addr;
      mem_we_d    = bus.in_host_we;
      mem_wdata_d = bus.in_host_wdata;
      ack_d       = 1'b1;
    end

    // Stage 1 of the tag pipe is the issued slot itself; tag_q is stage 2
    if (state_q == SLOT_DISP) begin
      tag_issue_c = TAG_DISP;
    end else if (state_q == SLOT_HOST && !bus.out_mem_we) begin
      tag_issue_c = TAG_HOST;
    end

    if (tag_q == TAG_DISP) begin
      disp_valid_d = 1'b1;
      disp_data_d  = bus.in_mem_rdata;
    end
    if (tag_q == TAG_HOST) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = bus.in_mem_rdata;
    end

    if (!bus.in_host_req || ack_d) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    starved_d = (cnt_d == CNT_W'(STARVE_LIMIT));
  end

  always_ff @(negedge in_vga_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q              <= SLOT_IDLE;
      tag_q                <= TAG_NONE;
      cnt_q                <= '0;
      bus.out_mem_addr     <= '0;
      bus.out_mem_we       <= 1'b0;
      bus.out_mem_wdata    <= '0;
      bus.out_host_ack     <= 1'b0;
      bus.out_host_starved <= 1'b0;
      bus.out_disp_valid   <= 1'b0;
      bus.out_disp_data    <= '0;
      bus.out_host_rvalid  <= 1'b0;
      bus.out_host_rdata   <= '0;
    end else begin
      state_q              <= slot_d;
      tag_q                <= tag_issue_c;
      cnt_q                <= cnt_d;
      bus.out_mem_addr     <= mem_addr_d;
      bus.out_mem_we       <= mem_we_d;
      bus.out_mem_wdata    <= mem_wdata_d;
      bus.out_host_ack     <= ack_d;
      bus.out_host_starved <= starved_d;
      bus.out_disp_valid   <= disp_valid_d;
      bus.out_disp_data    <= disp_data_d;
      bus.out_host_rvalid  <= host_rvalid_d;
      bus.out_host_rdata   <= host_rdata_d;
    end
  end

endmodule
